// File: rtl/dnn_pkg.sv
// Shared definitions for the dense-layer bus master.
//   state_t     : controller state encoding
//   WORD_STRIDE : byte distance between consecutive data words on the bus
package dnn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_BIAS,
        RD_W,
        RD_A,
        MAC,
        WR,
        DONE
    } state_t;

    localparam int WORD_STRIDE = 4;

endpackage

// File: rtl/dnn_mac.sv
// Fixed-point multiply / shift / accumulate unit.
//   clk, rst_n : clock, synchronous active-low reset (clears the accumulator)
//   clr        : start the next accumulation from zero (alone: zero the register)
//   en         : add (a*b) >>> FRAC_W to the accumulator
//   a, b       : signed operands with FRAC_W fractional bits
//   acc        : accumulator value
// Build option: DNN_DENSE_SATURATE_EN makes additions clamp to the signed
// DATA_W range instead of wrapping.
module dnn_mac #(
    parameter int DATA_W = 32,
    parameter int FRAC_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [DATA_W-1:0] acc
);

    localparam int PROD_W = 2 * DATA_W;

    logic signed [PROD_W-1:0] a_ext_p0;
    logic signed [PROD_W-1:0] b_ext_p0;
    logic signed [PROD_W-1:0] prod_p0;
    logic signed [PROD_W-1:0] shifted_p0;
    logic signed [DATA_W-1:0] base_p0;
    logic signed [DATA_W-1:0] acc_p1;

    // The sum is formed at full product width so an oversized product
    // saturates correctly rather than being truncated first.
    function automatic logic signed [DATA_W-1:0] acc_add(
        input logic signed [DATA_W-1:0] x,
        input logic signed [PROD_W-1:0] y
    );
        logic signed [PROD_W:0] s;
`ifdef DNN_DENSE_SATURATE_EN
        logic signed [PROD_W:0] sat_max;
        logic signed [PROD_W:0] sat_min;
        sat_max = {{(PROD_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
        sat_min = {{(PROD_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};
        s = (PROD_W+1)'(x) + (PROD_W+1)'(y);
        if (s > sat_max)
            return sat_max[DATA_W-1:0];
        else if (s < sat_min)
            return sat_min[DATA_W-1:0];
        else
            return s[DATA_W-1:0];
`else
        s = (PROD_W+1)'(x) + (PROD_W+1)'(y);
        return s[DATA_W-1:0];
`endif
    endfunction

    // Stage 0: full-width product, fractional realignment, accumulate base
    assign a_ext_p0   = PROD_W'(a);
    assign b_ext_p0   = PROD_W'(b);
    assign prod_p0    = a_ext_p0 * b_ext_p0;
    assign shifted_p0 = prod_p0 >>> FRAC_W;
    assign base_p0    = clr ? '0 : acc_p1;

    // Stage 1: accumulator register
    always_ff @(posedge clk) begin
        if (!rst_n)
            acc_p1 <= '0;
        else if (en)
            acc_p1 <= acc_add(base_p0, shifted_p0);
        else if (clr)
            acc_p1 <= '0;
    end

    assign acc = acc_p1;

endmodule

// File: rtl/dnn_dense_master.sv
// Dense (fully connected) layer engine with an Avalon-MM master port.
// Computes out[j] = act(bias[j] + sum_i W[j*in_len+i] * in[i]) by fetching
// one word at a time over the bus and writing each result back.
//   clk, rst_n            : clock, synchronous active-low reset
//   start                 : one-cycle run request (honoured only when idle)
//   bias_addr, weight_addr,
//   in_addr, out_addr     : byte base addresses of the four arrays
//   in_len, out_len       : vector lengths in words
//   relu                  : clamp negative results to zero
//   busy, done            : layer in progress / one-cycle completion pulse
//   m_*                   : Avalon-MM master (one read outstanding at most)
// Build option: DNN_DENSE_SATURATE_EN selects saturating accumulation.
module dnn_dense_master
    import dnn_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int FRAC_W = 16,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] bias_addr,
    input  logic [ADDR_W-1:0] weight_addr,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [ADDR_W-1:0] out_addr,
    input  logic [15:0]       in_len,
    input  logic [15:0]       out_len,
    input  logic              relu,
    output logic              busy,
    output logic              done,
    input  logic              m_waitrequest,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_read,
    output logic              m_write,
    input  logic [DATA_W-1:0] m_readdata,
    input  logic              m_readdatavalid,
    output logic [DATA_W-1:0] m_writedata
);

    // Fixed-point 1.0: loading the bias as bias*1.0 reuses the MAC path.
    localparam logic signed [DATA_W-1:0] ONE = DATA_W'(64'd1 << FRAC_W);

    state_t state, state_n;

    logic [ADDR_W-1:0] bias_base_q, weight_base_q, in_base_q, out_base_q;
    logic [15:0]       in_len_q, out_len_q;
    logic              relu_q;
    logic              snap;

    logic [15:0]       j_q, j_n, i_q, i_n;
    logic [ADDR_W-1:0] w_idx_q, w_idx_n;
    logic signed [DATA_W-1:0] w_q, w_n, a_q, a_n;

    logic              rd_wait, rd_wait_n;
    logic              m_read_n, m_write_n;
    logic [ADDR_W-1:0] m_address_n;
    logic [DATA_W-1:0] m_writedata_n;
    logic [ADDR_W-1:0] rd_addr;

    logic                     mac_clr, mac_en;
    logic signed [DATA_W-1:0] mac_a, mac_b, acc;
    logic signed [DATA_W-1:0] rdata_s;

    function automatic logic [ADDR_W-1:0] word_addr(
        input logic [ADDR_W-1:0] base,
        input logic [ADDR_W-1:0] idx
    );
        return base + idx * ADDR_W'(WORD_STRIDE);
    endfunction

    function automatic logic signed [DATA_W-1:0] act(
        input logic signed [DATA_W-1:0] x,
        input logic                     relu_en
    );
        return (relu_en && (x < 0)) ? '0 : x;
    endfunction

    assign rdata_s = signed'(m_readdata);
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

    dnn_mac #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (mac_clr),
        .en    (mac_en),
        .a     (mac_a),
        .b     (mac_b),
        .acc   (acc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            j_q         <= '0;
            i_q         <= '0;
            w_idx_q     <= '0;
            w_q         <= '0;
            a_q         <= '0;
            rd_wait     <= 1'b0;
            m_read      <= 1'b0;
            m_write     <= 1'b0;
            m_address   <= '0;
            m_writedata <= '0;
        end else begin
            state       <= state_n;
            j_q         <= j_n;
            i_q         <= i_n;
            w_idx_q     <= w_idx_n;
            w_q         <= w_n;
            a_q         <= a_n;
            rd_wait     <= rd_wait_n;
            m_read      <= m_read_n;
            m_write     <= m_write_n;
            m_address   <= m_address_n;
            m_writedata <= m_writedata_n;
        end
    end

    // Layer parameters are frozen at start so the caller may change them freely.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bias_base_q   <= '0;
            weight_base_q <= '0;
            in_base_q     <= '0;
            out_base_q    <= '0;
            in_len_q      <= '0;
            out_len_q     <= '0;
            relu_q        <= 1'b0;
        end else if (snap) begin
            bias_base_q   <= bias_addr;
            weight_base_q <= weight_addr;
            in_base_q     <= in_addr;
            out_base_q    <= out_addr;
            in_len_q      <= in_len;
            out_len_q     <= out_len;
            relu_q        <= relu;
        end
    end

    always_comb begin
        state_n       = state;
        j_n           = j_q;
        i_n           = i_q;
        w_idx_n       = w_idx_q;
        w_n           = w_q;
        a_n           = a_q;
        rd_wait_n     = rd_wait;
        m_read_n      = m_read;
        m_write_n     = m_write;
        m_address_n   = m_address;
        m_writedata_n = m_writedata;
        mac_clr       = 1'b0;
        mac_en        = 1'b0;
        mac_a         = w_q;
        mac_b         = a_q;
        snap          = 1'b0;

        case (state)
            RD_BIAS: rd_addr = word_addr(bias_base_q, ADDR_W'(j_q));
            RD_W:    rd_addr = word_addr(weight_base_q, w_idx_q);
            default: rd_addr = word_addr(in_base_q, ADDR_W'(i_q));
        endcase

        case (state)
            IDLE: begin
                if (start) begin
                    snap    = 1'b1;
                    j_n     = '0;
                    i_n     = '0;
                    w_idx_n = '0;
                    mac_clr = 1'b1;
                    state_n = (out_len == 16'd0) ? DONE : RD_BIAS;
                end
            end

            // Each read: issue, hold until accepted, then wait for its data.
            RD_BIAS, RD_W, RD_A: begin
                if (!m_read && !rd_wait) begin
                    m_read_n    = 1'b1;
                    m_address_n = rd_addr;
                end else if (m_read) begin
                    if (!m_waitrequest) begin
                        m_read_n  = 1'b0;
                        rd_wait_n = 1'b1;
                    end
                end else if (m_readdatavalid) begin
                    rd_wait_n = 1'b0;
                    case (state)
                        RD_BIAS: begin
                            mac_clr = 1'b1;
                            mac_en  = 1'b1;
                            mac_a   = rdata_s;
                            mac_b   = ONE;
                            state_n = (in_len_q == 16'd0) ? WR : RD_W;
                        end
                        RD_W: begin
                            w_n     = rdata_s;
                            w_idx_n = w_idx_q + 1'b1;
                            state_n = RD_A;
                        end
                        default: begin
                            a_n     = rdata_s;
                            state_n = MAC;
                        end
                    endcase
                end
            end

            MAC: begin
                mac_en  = 1'b1;
                i_n     = i_q + 16'd1;
                state_n = ((i_q + 16'd1) == in_len_q) ? WR : RD_W;
            end

            // First cycle latches the activated result, then hold until accepted.
            WR: begin
                if (!m_write) begin
                    m_write_n     = 1'b1;
                    m_address_n   = word_addr(out_base_q, ADDR_W'(j_q));
                    m_writedata_n = act(acc, relu_q);
                end else if (!m_waitrequest) begin
                    m_write_n = 1'b0;
                    if ((j_q + 16'd1) == out_len_q) begin
                        state_n = DONE;
                    end else begin
                        j_n     = j_q + 16'd1;
                        i_n     = '0;
                        state_n = RD_BIAS;
                    end
                end
            end

            DONE: state_n = IDLE;

            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dnn_dense_master.sv
module tb_dnn_dense_master;

    localparam logic [31:0] BIAS = 32'h100;
    localparam logic [31:0] WGT  = 32'h200;
    localparam logic [31:0] INB  = 32'h300;
    localparam logic [31:0] OUTB = 32'h380;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] bias_addr, weight_addr, in_addr, out_addr;
    logic [15:0] in_len, out_len;
    logic        relu;
    logic        busy, done;
    logic        m_waitrequest;
    logic [31:0] m_address;
    logic        m_read, m_write;
    logic [31:0] m_readdata;
    logic        m_readdatavalid;
    logic [31:0] m_writedata;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem [0:255];
    int          stall = 0;
    int          rd_cnt = 0, wr_cnt = 0, cmd_seen = 0, stall_seen = 0;
    int          unstable = 0, done_cnt = 0;

    dnn_dense_master dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .bias_addr       (bias_addr),
        .weight_addr     (weight_addr),
        .in_addr         (in_addr),
        .out_addr        (out_addr),
        .in_len          (in_len),
        .out_len         (out_len),
        .relu            (relu),
        .busy            (busy),
        .done            (done),
        .m_waitrequest   (m_waitrequest),
        .m_address       (m_address),
        .m_read          (m_read),
        .m_write         (m_write),
        .m_readdata      (m_readdata),
        .m_readdatavalid (m_readdatavalid),
        .m_writedata     (m_writedata)
    );

    always #5 clk = ~clk;

    // Avalon slave: reacts on the falling edge, data returns one cycle after acceptance.
    initial begin
        int          wcnt;
        logic        ret_pend;
        logic [31:0] ret_data, c_addr, c_data;
        logic        c_wr;
        wcnt = 0; ret_pend = 1'b0; ret_data = '0;
        c_addr = '0; c_data = '0; c_wr = 1'b0;
        m_waitrequest = 1'b0; m_readdatavalid = 1'b0; m_readdata = '0;
        forever begin
            @(negedge clk);
            if (ret_pend) begin
                m_readdatavalid = 1'b1;
                m_readdata      = ret_data;
                ret_pend        = 1'b0;
            end else begin
                m_readdatavalid = 1'b0;
            end
            if (!rst_n) begin
                m_waitrequest = 1'b0;
                wcnt = 0;
            end else if (m_read || m_write) begin
                cmd_seen++;
                if (wcnt == 0) begin
                    c_addr = m_address; c_wr = m_write; c_data = m_writedata;
                end else if (m_address !== c_addr || m_write !== c_wr || m_read !== !c_wr
                             || (c_wr && m_writedata !== c_data)) begin
                    unstable++;
                end
                if (wcnt < stall) begin
                    m_waitrequest = 1'b1;
                    wcnt++;
                    stall_seen++;
                end else begin
                    m_waitrequest = 1'b0;
                    wcnt = 0;
                    if (m_write) begin
                        mem[m_address[9:2]] = m_writedata;
                        wr_cnt++;
                    end else begin
                        ret_pend = 1'b1;
                        ret_data = mem[m_address[9:2]];
                        rd_cnt++;
                    end
                end
            end else begin
                m_waitrequest = 1'b0;
                wcnt = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic run_layer(input string tag, input logic [15:0] il, input logic [15:0] ol,
                             input logic rl, output int cyc);
        int d0;
        d0 = done_cnt;
        @(negedge clk);
        bias_addr = BIAS; weight_addr = WGT; in_addr = INB; out_addr = OUTB;
        in_len = il; out_len = ol; relu = rl; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // scramble inputs; the running layer must not see these
        bias_addr = 32'h3F0; weight_addr = 32'h3F4; in_addr = 32'h3F8; out_addr = 32'h3FC;
        in_len = 16'd7; out_len = 16'd9; relu = ~rl;
        chk({tag, "_busy"}, busy, 1);
        cyc = 1;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_done_seen"}, done, 1);
        repeat (3) @(negedge clk);
        chk({tag, "_done_pulses"}, done_cnt - d0, 1);
        chk({tag, "_idle"}, busy, 0);
    endtask

    task automatic load_base();
        mem[BIAS[9:2]]      = 32'h0001_0000;
        mem[BIAS[9:2] + 1]  = 32'h0000_0000;
        mem[WGT[9:2]]       = 32'h0001_0000;
        mem[WGT[9:2] + 1]   = 32'h0002_0000;
        mem[WGT[9:2] + 2]   = 32'h0003_0000;
        mem[WGT[9:2] + 3]   = 32'hFFFF_0000;
        mem[INB[9:2]]       = 32'h0000_8000;
        mem[INB[9:2] + 1]   = 32'h0000_4000;
        mem[OUTB[9:2]]      = 32'hDEAD_BEEF;
        mem[OUTB[9:2] + 1]  = 32'hDEAD_BEEF;
    endtask

    initial begin
        int cyc, w0, r0, c0, s0, u0, n;
        for (int k = 0; k < 256; k++) mem[k] = '0;
        rst_n = 1'b0; start = 1'b0; relu = 1'b0;
        bias_addr = '0; weight_addr = '0; in_addr = '0; out_addr = '0;
        in_len = '0; out_len = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {busy, done, m_read, m_write, m_address, m_writedata}, 0);
        rst_n = 1'b1;

        // basic layer: 1 + 1.0*0.5 + 2.0*0.25 = 2.0
        load_base();
        w0 = wr_cnt;
        run_layer("basic", 16'd2, 16'd1, 1'b0, cyc);
        chk("basic_out", mem[OUTB[9:2]], 32'h0002_0000);
        chk("basic_out1_untouched", mem[OUTB[9:2] + 1], 32'hDEAD_BEEF);
        chk("basic_writes", wr_cnt - w0, 1);

        // negative bias: -3 + 1 = -2.0
        load_base();
        mem[BIAS[9:2]] = 32'hFFFD_0000;
        run_layer("neg_relu", 16'd2, 16'd1, 1'b1, cyc);
        chk("neg_relu_out", mem[OUTB[9:2]], 32'h0000_0000);
        mem[OUTB[9:2]] = 32'hDEAD_BEEF;
        run_layer("neg_id", 16'd2, 16'd1, 1'b0, cyc);
        chk("neg_id_out", mem[OUTB[9:2]], 32'hFFFE_0000);
        mem[BIAS[9:2]] = 32'hFFFE_0000;
        run_layer("neg1_id", 16'd2, 16'd1, 1'b0, cyc);
        chk("neg1_id_out", mem[OUTB[9:2]], 32'hFFFF_0000);

        // two outputs: row 1 = 0 + 3.0*0.5 - 1.0*0.25 = 1.25
        load_base();
        w0 = wr_cnt;
        run_layer("two_out", 16'd2, 16'd2, 1'b0, cyc);
        chk("two_out0", mem[OUTB[9:2]], 32'h0002_0000);
        chk("two_out1", mem[OUTB[9:2] + 1], 32'h0001_4000);
        chk("two_out_writes", wr_cnt - w0, 2);

        // 5 wait states on every command (5 reads + 1 write)
        load_base();
        stall = 5;
        w0 = wr_cnt; s0 = stall_seen; u0 = unstable;
        run_layer("stall", 16'd2, 16'd1, 1'b0, cyc);
        chk("stall_out", mem[OUTB[9:2]], 32'h0002_0000);
        chk("stall_cycles", stall_seen - s0, 30);
        chk("stall_stable", unstable - u0, 0);
        chk("stall_writes", wr_cnt - w0, 1);
        stall = 0;

        // empty layer: no bus traffic at all
        load_base();
        c0 = cmd_seen;
        run_layer("empty", 16'd2, 16'd0, 1'b0, cyc);
        chk("empty_fast", cyc <= 3, 1);
        chk("empty_no_bus", cmd_seen - c0, 0);
        chk("empty_out_untouched", mem[OUTB[9:2]], 32'hDEAD_BEEF);

        // zero-length input: output is just the bias
        load_base();
        mem[BIAS[9:2]] = 32'h0002_0000;
        r0 = rd_cnt;
        run_layer("in0", 16'd0, 16'd1, 1'b0, cyc);
        chk("in0_out", mem[OUTB[9:2]], 32'h0002_0000);
        chk("in0_reads", rd_cnt - r0, 1);

        // reset while the second input word is being read
        load_base();
        @(negedge clk);
        bias_addr = BIAS; weight_addr = WGT; in_addr = INB; out_addr = OUTB;
        in_len = 16'd2; out_len = 16'd1; relu = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(m_read && m_address == INB + 32'd4) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reach_rd_a2", n < 500, 1);
        #1 rst_n = 1'b0;
        w0 = wr_cnt;
        @(negedge clk);
        chk("rst_mid_outputs", {busy, done, m_read, m_write, m_address, m_writedata}, 0);
        chk("rst_late_valid_present", m_readdatavalid, 1);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_stays_idle", {busy, done, m_read, m_write}, 0);
        chk("rst_no_write", wr_cnt - w0, 0);
        chk("rst_out_untouched", mem[OUTB[9:2]], 32'hDEAD_BEEF);
        run_layer("after_rst", 16'd2, 16'd1, 1'b0, cyc);
        chk("after_rst_out", mem[OUTB[9:2]], 32'h0002_0000);

        // overflow: 0x7FFF0000 * 2.0
        load_base();
        mem[BIAS[9:2]] = 32'h0;
        mem[WGT[9:2]]  = 32'h7FFF_0000;
        mem[INB[9:2]]  = 32'h0002_0000;
        run_layer("ovf", 16'd1, 16'd1, 1'b0, cyc);
`ifdef DNN_DENSE_SATURATE_EN
        chk("ovf_out", mem[OUTB[9:2]], 32'h7FFF_FFFF);
`else
        chk("ovf_out", mem[OUTB[9:2]], 32'hFFFE_0000);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
